// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command parser: header bytes,
// command codes, response codes, per-command payload lengths, channel write bundle.
package uart_cmd_pkg;

    localparam logic [7:0] HDR0_BYTE = 8'hAA;
    localparam logic [7:0] HDR1_BYTE = 8'h55;

    localparam logic [7:0] CMD_RES = 8'h01;
    localparam logic [7:0] CMD_FMT = 8'h02;
    localparam logic [7:0] CMD_ALG = 8'h03;
    localparam logic [7:0] CMD_BIA = 8'h04;

    localparam logic [1:0] RESP_OK      = 2'd0;
    localparam logic [1:0] RESP_CSUM    = 2'd1;
    localparam logic [1:0] RESP_BAD     = 2'd2;
    localparam logic [1:0] RESP_TIMEOUT = 2'd3;

    localparam logic [7:0] LEN_RES = 8'd4;
    localparam logic [7:0] LEN_FMT = 8'd1;
    localparam logic [7:0] LEN_ALG = 8'd1;
    localparam logic [7:0] LEN_BIA = 8'd2;

    // Zero marks an unknown command.
    function automatic logic [7:0] cmd_len(input logic [7:0] cmd);
        case (cmd)
            CMD_RES: cmd_len = LEN_RES;
            CMD_FMT: cmd_len = LEN_FMT;
            CMD_ALG: cmd_len = LEN_ALG;
            CMD_BIA: cmd_len = LEN_BIA;
            default: cmd_len = 8'd0;
        endcase
    endfunction

    typedef struct packed {
        logic        res;
        logic        fmt;
        logic        alg;
        logic        bia;
        logic [11:0] x;
        logic [11:0] y;
        logic        fmt_v;
        logic [1:0]  alg_v;
        logic [8:0]  bia_v;
    } ch_wr_t;

endpackage

// File: rtl/uart_ch_regs.sv
// One scaler channel's configuration registers; data arrives already clamped
// and filtered, so each strobe is a plain load.
module uart_ch_regs
    import uart_cmd_pkg::*;
#(
    parameter int X_RST   = 640,
    parameter int Y_RST   = 480,
    parameter int BIA_RST = 128
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  ch_wr_t      wr,
    output logic [11:0] x_pix_len,
    output logic [11:0] y_pix_len,
    output logic        pix_len_update,
    output logic [1:0]  algorithm,
    output logic        vid_format,
    output logic [8:0]  bi_a
);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            x_pix_len      <= 12'(X_RST);
            y_pix_len      <= 12'(Y_RST);
            pix_len_update <= 1'b0;
            algorithm      <= 2'd0;
            vid_format     <= 1'b0;
            bi_a           <= 9'(BIA_RST);
        end else begin
            pix_len_update <= wr.res;
            if (wr.res) begin
                x_pix_len <= wr.x;
                y_pix_len <= wr.y;
            end
            if (wr.fmt) vid_format <= wr.fmt_v;
            if (wr.alg) algorithm  <= wr.alg_v;
            if (wr.bia) bi_a       <= wr.bia_v;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Framed UART command parser: AA 55 CMD CH LEN payload CSUM, with inter-byte
// timeout, per-channel scaler configuration and a response/error report.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int TIMEOUT_CYC = 5_000_000,
    parameter int X_MIN       = 640,
    parameter int X_MAX       = 2560,
    parameter int Y_MIN       = 480,
    parameter int Y_MAX       = 1440,
    parameter int X_RST       = 640,
    parameter int Y_RST       = 480,
    parameter int BIA_RST     = 128
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  uart_rx_flag,
    input  logic [7:0]            uart_rx_data,
    output logic [12*NUM_CH-1:0]  x_pix_len,
    output logic [12*NUM_CH-1:0]  y_pix_len,
    output logic [NUM_CH-1:0]     pix_len_update,
    output logic [2*NUM_CH-1:0]   algorithm,
    output logic [NUM_CH-1:0]     vid_format,
    output logic [9*NUM_CH-1:0]   bi_a,
    output logic                  resp_valid,
    output logic [1:0]            resp_code,
    output logic [15:0]           err_cnt
);

    localparam logic [2:0] S_HDR0    = 3'd0;
    localparam logic [2:0] S_HDR1    = 3'd1;
    localparam logic [2:0] S_CMD     = 3'd2;
    localparam logic [2:0] S_CH      = 3'd3;
    localparam logic [2:0] S_LEN     = 3'd4;
    localparam logic [2:0] S_PAYLOAD = 3'd5;
    localparam logic [2:0] S_CSUM    = 3'd6;
    localparam logic [2:0] S_COMMIT  = 3'd7;

    localparam int GW = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]    state;
    logic [7:0]    cmd_q, ch_q, csum_q;
    logic [2:0]    len_cnt;
    logic [31:0]   pbuf;
    logic [GW-1:0] gap_cnt;
    logic          timeout, len_ok, commit;
    logic [11:0]   x_clamped, y_clamped;
    logic          unused_pbuf;

    function automatic logic [11:0] clamp(input logic [11:0] v, input int lo, input int hi);
        if (v < 12'(lo))      clamp = 12'(lo);
        else if (v > 12'(hi)) clamp = 12'(hi);
        else                  clamp = v;
    endfunction

    assign len_ok  = (cmd_len(cmd_q) != 8'd0) && (ch_q < 8'(NUM_CH)) &&
                     (uart_rx_data == cmd_len(cmd_q));
    assign timeout = (state != S_HDR0) && (state != S_COMMIT) && !uart_rx_flag &&
                     (gap_cnt == GW'(TIMEOUT_CYC - 1));
    assign commit  = (state == S_COMMIT);

    assign x_clamped   = clamp(pbuf[27:16], X_MIN, X_MAX);
    assign y_clamped   = clamp(pbuf[11:0],  Y_MIN, Y_MAX);
    assign unused_pbuf = ^{pbuf[31:28], pbuf[15:12]};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= S_HDR0;
            cmd_q      <= 8'd0;
            ch_q       <= 8'd0;
            csum_q     <= 8'd0;
            len_cnt    <= 3'd0;
            pbuf       <= 32'd0;
            gap_cnt    <= '0;
            resp_valid <= 1'b0;
            resp_code  <= RESP_OK;
        end else begin
            resp_valid <= 1'b0;
            if (uart_rx_flag || state == S_HDR0 || state == S_COMMIT)
                gap_cnt <= '0;
            else
                gap_cnt <= gap_cnt + 1'b1;

            if (timeout) begin
                state      <= S_HDR0;
                resp_valid <= 1'b1;
                resp_code  <= RESP_TIMEOUT;
            end else begin
                case (state)
                    S_HDR0: if (uart_rx_flag && uart_rx_data == HDR0_BYTE) state <= S_HDR1;
                    S_HDR1: if (uart_rx_flag) begin
                        // A repeated 0xAA may be the real start of frame.
                        if (uart_rx_data == HDR1_BYTE)      state <= S_CMD;
                        else if (uart_rx_data != HDR0_BYTE) state <= S_HDR0;
                    end
                    S_CMD: if (uart_rx_flag) begin
                        cmd_q  <= uart_rx_data;
                        csum_q <= uart_rx_data;
                        state  <= S_CH;
                    end
                    S_CH: if (uart_rx_flag) begin
                        ch_q   <= uart_rx_data;
                        csum_q <= csum_q ^ uart_rx_data;
                        state  <= S_LEN;
                    end
                    S_LEN: if (uart_rx_flag) begin
                        csum_q <= csum_q ^ uart_rx_data;
                        if (len_ok) begin
                            len_cnt <= uart_rx_data[2:0];
                            state   <= S_PAYLOAD;
                        end else begin
                            state      <= S_HDR0;
                            resp_valid <= 1'b1;
                            resp_code  <= RESP_BAD;
                        end
                    end
                    S_PAYLOAD: if (uart_rx_flag) begin
                        pbuf    <= {pbuf[23:0], uart_rx_data};
                        csum_q  <= csum_q ^ uart_rx_data;
                        len_cnt <= len_cnt - 3'd1;
                        if (len_cnt == 3'd1) state <= S_CSUM;
                    end
                    S_CSUM: if (uart_rx_flag) begin
                        if (uart_rx_data == csum_q) begin
                            state <= S_COMMIT;
                        end else begin
                            state      <= S_HDR0;
                            resp_valid <= 1'b1;
                            resp_code  <= RESP_CSUM;
                        end
                    end
                    S_COMMIT: begin
                        state      <= S_HDR0;
                        resp_valid <= 1'b1;
                        resp_code  <= RESP_OK;
                    end
                    default: state <= S_HDR0;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            err_cnt <= 16'd0;
        else if (resp_valid && resp_code != RESP_OK && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ch_wr_t wr;
        logic   hit;

        assign hit = commit && (ch_q == 8'(c));

        // Out-of-range algorithm/format values complete the frame but are not stored.
        always_comb begin
            wr       = '0;
            wr.res   = hit && (cmd_q == CMD_RES);
            wr.fmt   = hit && (cmd_q == CMD_FMT) && (pbuf[7:0] <= 8'd1);
            wr.alg   = hit && (cmd_q == CMD_ALG) && (pbuf[7:0] <= 8'd2);
            wr.bia   = hit && (cmd_q == CMD_BIA);
            wr.x     = x_clamped;
            wr.y     = y_clamped;
            wr.fmt_v = pbuf[0];
            wr.alg_v = pbuf[1:0];
            wr.bia_v = pbuf[8:0];
        end

        uart_ch_regs #(
            .X_RST   (X_RST),
            .Y_RST   (Y_RST),
            .BIA_RST (BIA_RST)
        ) u_regs (
            .sys_clk        (sys_clk),
            .sys_rst        (sys_rst),
            .wr             (wr),
            .x_pix_len      (x_pix_len[12*c +: 12]),
            .y_pix_len      (y_pix_len[12*c +: 12]),
            .pix_len_update (pix_len_update[c]),
            .algorithm      (algorithm[2*c +: 2]),
            .vid_format     (vid_format[c]),
            .bi_a           (bi_a[9*c +: 9])
        );
    end

endmodule
